multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle decoder: a Moore FSM that sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB over a shared memory port.
- Adds a memory ready handshake with a bounded wait, a halt/fault path and a retired-instruction counter.
- Sits between the instruction register and the multi-cycle datapath.
- Opcode decode uses the shared `OPCODE_* 5-bit definitions (instr[6:2]).

Parameters:
- MEM_TIMEOUT, 15, maximum cycles in FETCH/MEM waiting for mem_ready before fault; range 1..255.
- CNT_W, 32, width of instret counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  5  instr[6:2] from instruction register, valid from DECODE onward
- funct7_b0  in  1  instr[25], used only with MDU_EN
- mem_ready  in  1  memory completes current request this cycle
- mdu_done  in  1  multiply/divide unit result valid (MDU_EN only)
- mem_req  out  1  memory access request
- mem_we  out  1  request is a write
- iord  out  1  0 = address from PC, 1 = address from ALU result register
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update if branch-taken flag set
- alu_src_a  out  2  00 PC, 01 rs1, 10 zero
- alu_src_b  out  2  00 rs2, 01 const 4, 10 immediate
- alu_op  out  3  000 add, 001 branch compare, 010 R-type funct, 011 I-type funct
- wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4, 11 MDU
- reg_write  out  1  register file write enable
- mdu_start  out  1  one-cycle start pulse to MDU
- halted  out  1  FSM in HALT
- fault  out  2  00 none, 01 illegal opcode, 10 memory timeout
- instret  out  CNT_W  retired instruction count

Behaviour:
- States: RST, FETCH, DECODE, EXEC, MEM, WB, MDU, HALT. Outputs are decoded from the state register plus the opcode latched at DECODE.
- While rst_n = 0: state = RST, all outputs 0, instret = 0, fault = 00, wait counter = 0.
- RST -> FETCH on the first clock edge after reset deassertion.
- FETCH:
  - mem_req = 1, iord = 0, alu_src_a = 00, alu_src_b = 01, alu_op = 000.
  - On mem_ready: ir_write = 1 and pc_write = 1 in that same cycle, then -> DECODE.
  - Wait counter increments each cycle without mem_ready. On reaching MEM_TIMEOUT: -> HALT, fault = 10.
- DECODE (1 cycle): alu_src_a = 00, alu_src_b = 10 (branch target precompute), latch opcode. Next state:
  - Load/Store/Arith_R/Arith_I/LUI/AUIPC/Branch/JAL/JALR -> EXEC.
  - SYSTEM or Custom -> HALT, fault = 00.
  - Any other opcode -> HALT, fault = 01.
- EXEC (1 cycle):
  - Load/Store: alu_src_a = 01, alu_src_b = 10, alu_op = 000; -> MEM.
  - R: 01/00/010; -> WB.
  - I: 01/10/011; -> WB.
  - LUI: 10/10/000; -> WB.
  - AUIPC: a = 00, b = 10, alu_op = 000; the PC used is the current-instruction PC held by the datapath; -> WB.
  - Branch: 01/00/001, pc_write_cond = 1; instruction retires; -> FETCH.
  - JAL: a = 00, b = 10, pc_write = 1; -> WB with wb_sel = 10.
  - JALR: a = 01, b = 10, pc_write = 1; -> WB with wb_sel = 10.
- MEM:
  - mem_req = 1, iord = 1, mem_we = 1 for Store.
  - On mem_ready: Store retires and -> FETCH; Load -> WB.
  - Timeout handled as in FETCH.
- WB (1 cycle): reg_write = 1, wb_sel per opcode (Load 01, JAL/JALR 10, else 00); retires; -> FETCH.
- Retire: instret increments by 1 on the cycle the FSM leaves for FETCH after completing an instruction. It wraps modulo 2^CNT_W. HALT entries do not count.
- Wait counter clears on every state change.
- mem_ready outside FETCH/MEM is ignored.
- mem_ready in the same cycle the counter hits MEM_TIMEOUT: completion wins, no fault.
- HALT is absorbing: all strobes 0, halted = 1, fault held. Only rst_n exits.
- Reset asserted mid-instruction: immediate return to RST; no partial strobes after assertion.

Optional Feature:
- Macro: MULTICYCLE_MDU_EN.
- Defined:
  - Arith_R with funct7_b0 = 1 goes EXEC -> MDU. mdu_start = 1 on the EXEC cycle only.
  - MDU waits for mdu_done with no timeout, then -> WB with wb_sel = 11.
- Undefined:
  - funct7_b0 and mdu_done are ignored; mdu_start is tied 0; the MDU state does not exist.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles, release -> all outputs 0 during reset; state FETCH with mem_req = 1 on the 2nd edge after release.
- R-type (01100), mem_ready on 1st FETCH cycle -> 4 states FETCH/DECODE/EXEC/WB; reg_write pulses once; instret 0 -> 1.
- Load (00000) with mem_ready delayed 3 cycles in MEM -> 8 cycles total; wb_sel = 01 in WB.
- Store (01000) -> mem_we = 1 and iord = 1 in MEM; no reg_write; instret increments.
- mem_ready held 0 with MEM_TIMEOUT = 15 -> HALT after 15 FETCH cycles, fault = 10, halted = 1, instret unchanged.
- Illegal opcode 11111 -> HALT, fault = 01. SYSTEM (11100) -> HALT, fault = 00. With MULTICYCLE_MDU_EN: R-type with funct7_b0 = 1 and mdu_done after 5 cycles -> single mdu_start pulse, then wb_sel = 11.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multi-cycle control unit (master) and the
// datapath/memory side (slave).
interface multicycle_control_unit_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       opcode;
   logic             funct7_b0;
   logic             mem_ready;
   logic             mdu_done;
   logic             mem_req;
   logic             mem_we;
   logic             iord;
   logic             ir_write;
   logic             pc_write;
   logic             pc_write_cond;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [2:0]       alu_op;
   logic [1:0]       wb_sel;
   logic             reg_write;
   logic             mdu_start;
   logic             halted;
   logic [1:0]       fault;
   logic [CNT_W-1:0] instret;

   modport master (
      input  opcode, funct7_b0, mem_ready, mdu_done,
      output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
             alu_src_a, alu_src_b, alu_op, wb_sel, reg_write, mdu_start,
             halted, fault, instret
   );

   modport slave (
      output opcode, funct7_b0, mem_ready, mdu_done,
      input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
             alu_src_a, alu_src_b, alu_op, wb_sel, reg_write, mdu_start,
             halted, fault, instret
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing RV32I instructions through FETCH/DECODE/EXEC/MEM/WB over a
// shared memory port. Optional multiply/divide sequencing: define MULTICYCLE_MDU_EN.
`ifndef OPCODE_LOAD
`define OPCODE_LOAD    5'b00000
`endif
`ifndef OPCODE_CUSTOM0
`define OPCODE_CUSTOM0 5'b00010
`endif
`ifndef OPCODE_ARITH_I
`define OPCODE_ARITH_I 5'b00100
`endif
`ifndef OPCODE_AUIPC
`define OPCODE_AUIPC   5'b00101
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE   5'b01000
`endif
`ifndef OPCODE_CUSTOM1
`define OPCODE_CUSTOM1 5'b01010
`endif
`ifndef OPCODE_ARITH_R
`define OPCODE_ARITH_R 5'b01100
`endif
`ifndef OPCODE_LUI
`define OPCODE_LUI     5'b01101
`endif
`ifndef OPCODE_CUSTOM2
`define OPCODE_CUSTOM2 5'b10110
`endif
`ifndef OPCODE_BRANCH
`define OPCODE_BRANCH  5'b11000
`endif
`ifndef OPCODE_JALR
`define OPCODE_JALR    5'b11001
`endif
`ifndef OPCODE_JAL
`define OPCODE_JAL     5'b11011
`endif
`ifndef OPCODE_SYSTEM
`define OPCODE_SYSTEM  5'b11100
`endif
`ifndef OPCODE_CUSTOM3
`define OPCODE_CUSTOM3 5'b11110
`endif

module multicycle_control_unit #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   multicycle_control_unit_if.master  bus
);

`ifdef MULTICYCLE_MDU_EN
   typedef enum logic [2:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_MDU, S_HALT
   } state_t;
`else
   typedef enum logic [2:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;
`endif

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
   localparam logic [1:0] FLT_NONE  = 2'b00;
   localparam logic [1:0] FLT_ILL   = 2'b01;
   localparam logic [1:0] FLT_MEM   = 2'b10;

   state_t           state_q, state_d;
   logic [4:0]       op_q, op_d;
   logic             f7_q, f7_d;
   logic [7:0]       wait_q, wait_d;
   logic [1:0]       fault_q, fault_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RST;
         op_q      <= 5'b0;
         f7_q      <= 1'b0;
         wait_q    <= 8'b0;
         fault_q   <= FLT_NONE;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         f7_q      <= f7_d;
         wait_q    <= wait_d;
         fault_q   <= fault_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      f7_d    = f7_q;
      fault_d = fault_q;
      retire  = 1'b0;
      case (state_q)
         S_RST: state_d = S_FETCH;
         S_FETCH: begin
            // Completion beats the timeout when both land in the same cycle.
            if (bus.mem_ready) begin
               state_d = S_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_HALT;
               fault_d = FLT_MEM;
            end
         end
         S_DECODE: begin
            op_d = bus.opcode;
`ifdef MULTICYCLE_MDU_EN
            f7_d = bus.funct7_b0;
`endif
            case (bus.opcode)
               `OPCODE_LOAD, `OPCODE_STORE, `OPCODE_ARITH_R, `OPCODE_ARITH_I,
               `OPCODE_LUI, `OPCODE_AUIPC, `OPCODE_BRANCH, `OPCODE_JAL,
               `OPCODE_JALR: state_d = S_EXEC;
               `OPCODE_SYSTEM, `OPCODE_CUSTOM0, `OPCODE_CUSTOM1,
               `OPCODE_CUSTOM2, `OPCODE_CUSTOM3: begin
                  state_d = S_HALT;
                  fault_d = FLT_NONE;
               end
               default: begin
                  state_d = S_HALT;
                  fault_d = FLT_ILL;
               end
            endcase
         end
         S_EXEC: begin
            case (op_q)
               `OPCODE_LOAD, `OPCODE_STORE: state_d = S_MEM;
               `OPCODE_BRANCH: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               default: state_d = S_WB;
            endcase
`ifdef MULTICYCLE_MDU_EN
            if (op_q == `OPCODE_ARITH_R && f7_q) state_d = S_MDU;
`endif
         end
         S_MEM: begin
            if (bus.mem_ready) begin
               if (op_q == `OPCODE_STORE) begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_HALT;
               fault_d = FLT_MEM;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
`ifdef MULTICYCLE_MDU_EN
         S_MDU: if (bus.mdu_done) state_d = S_WB;
`endif
         S_HALT: state_d = S_HALT;
         default: state_d = S_HALT;
      endcase

      if (state_d != state_q) wait_d = 8'b0;
      else if (state_q == S_FETCH || state_q == S_MEM) wait_d = wait_q + 8'd1;
      else wait_d = wait_q;

      instret_d = retire ? instret_q + 1'b1 : instret_q;
   end

   // Strobes decode from the state register; only the FETCH completion strobes
   // follow mem_ready so the IR and PC load in the completing cycle.
   always_comb begin
      bus.mem_req       = 1'b0;
      bus.mem_we        = 1'b0;
      bus.iord          = 1'b0;
      bus.ir_write      = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.alu_src_a     = 2'b00;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 3'b000;
      bus.wb_sel        = 2'b00;
      bus.reg_write     = 1'b0;
      bus.mdu_start     = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.mem_req   = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         S_DECODE: bus.alu_src_b = 2'b10;
         S_EXEC: begin
            case (op_q)
               `OPCODE_LOAD, `OPCODE_STORE: begin
                  bus.alu_src_a = 2'b01;
                  bus.alu_src_b = 2'b10;
               end
               `OPCODE_ARITH_R: begin
                  bus.alu_src_a = 2'b01;
                  bus.alu_op    = 3'b010;
`ifdef MULTICYCLE_MDU_EN
                  bus.mdu_start = f7_q;
`endif
               end
               `OPCODE_ARITH_I: begin
                  bus.alu_src_a = 2'b01;
                  bus.alu_src_b = 2'b10;
                  bus.alu_op    = 3'b011;
               end
               `OPCODE_LUI: begin
                  bus.alu_src_a = 2'b10;
                  bus.alu_src_b = 2'b10;
               end
               `OPCODE_AUIPC: bus.alu_src_b = 2'b10;
               `OPCODE_BRANCH: begin
                  bus.alu_src_a     = 2'b01;
                  bus.alu_op        = 3'b001;
                  bus.pc_write_cond = 1'b1;
               end
               `OPCODE_JAL: begin
                  bus.alu_src_b = 2'b10;
                  bus.pc_write  = 1'b1;
               end
               `OPCODE_JALR: begin
                  bus.alu_src_a = 2'b01;
                  bus.alu_src_b = 2'b10;
                  bus.pc_write  = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            bus.mem_req = 1'b1;
            bus.iord    = 1'b1;
            bus.mem_we  = (op_q == `OPCODE_STORE);
         end
         S_WB: begin
            bus.reg_write = 1'b1;
            if (op_q == `OPCODE_LOAD) bus.wb_sel = 2'b01;
            else if (op_q == `OPCODE_JAL || op_q == `OPCODE_JALR) bus.wb_sel = 2'b10;
`ifdef MULTICYCLE_MDU_EN
            else if (op_q == `OPCODE_ARITH_R && f7_q) bus.wb_sel = 2'b11;
`endif
         end
         default: ;
      endcase
   end

`ifndef MULTICYCLE_MDU_EN
   logic unused_mdu_inputs;
   assign unused_mdu_inputs = bus.funct7_b0 ^ bus.mdu_done ^ f7_q;
`endif

   assign bus.halted  = (state_q == S_HALT);
   assign bus.fault   = fault_q;
   assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit; MDU scenario is selected by
// MULTICYCLE_MDU_EN to match the DUT build.
module tb_multicycle_control_unit;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   multicycle_control_unit_if #(.CNT_W(32)) bus ();

   multicycle_control_unit #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Output vector: {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
   //                 alu_src_a, alu_src_b, alu_op, wb_sel, reg_write, mdu_start, halted, fault}
   function automatic logic [19:0] ev(input logic mr, we, io, irw, pcw, pcc,
                                      input logic [1:0] a, b, input logic [2:0] op,
                                      input logic [1:0] wb, input logic rw, ms, h,
                                      input logic [1:0] f);
      return {mr, we, io, irw, pcw, pcc, a, b, op, wb, rw, ms, h, f};
   endfunction

   function automatic logic [19:0] outs();
      return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
              bus.pc_write_cond, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
              bus.wb_sel, bus.reg_write, bus.mdu_start, bus.halted, bus.fault};
   endfunction

   logic [19:0] v_zero, v_fetch, v_fetch_rdy, v_decode, v_exec_r, v_exec_ls, v_wb_alu;

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mdu_done  = 1'b0;
      bus.funct7_b0 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      bus.mdu_done  = 1'b0;
      bus.funct7_b0 = 1'b0;
      bus.opcode    = 5'b01100;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (outs() !== v_zero) begin
         errors++; $display("FAIL reset_outputs: got %h expected %h", outs(), v_zero);
      end
      checks++;
      if (bus.instret !== 32'd0) begin
         errors++; $display("FAIL reset_instret: got %0d expected 0", bus.instret);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (outs() !== v_zero) begin
         errors++; $display("FAIL reset_release_rst_state: got %h expected %h", outs(), v_zero);
      end
      @(negedge clk);
      #1;
      checks++;
      if (outs() !== v_fetch) begin
         errors++; $display("FAIL reset_first_fetch: got %h expected %h", outs(), v_fetch);
      end
   endtask

   task automatic test_rtype();
      logic        mr  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
      logic [19:0] exp [4];
      exp = '{v_fetch_rdy, v_decode, v_exec_r, v_wb_alu};
      bus.opcode = 5'b01100;
      for (int i = 0; i < 4; i++) begin
         bus.mem_ready = mr[i];
         #1;
         checks++;
         if (outs() !== exp[i]) begin
            errors++; $display("FAIL rtype cycle %0d: got %h expected %h", i, outs(), exp[i]);
         end
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (outs() !== v_fetch || bus.instret !== 32'd1) begin
         errors++; $display("FAIL rtype_retire: got %h/%0d expected %h/1", outs(), bus.instret, v_fetch);
      end
   endtask

   task automatic test_load();
      logic        mr  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [19:0] exp [8];
      logic [19:0] v_mem;
      v_mem = ev(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0,0,2'b00);
      exp = '{v_fetch_rdy, v_decode, v_exec_ls, v_mem, v_mem, v_mem, v_mem,
              ev(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b01,1,0,0,2'b00)};
      bus.opcode = 5'b00000;
      for (int i = 0; i < 8; i++) begin
         bus.mem_ready = mr[i];
         #1;
         checks++;
         if (outs() !== exp[i]) begin
            errors++; $display("FAIL load cycle %0d: got %h expected %h", i, outs(), exp[i]);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (outs() !== v_fetch || bus.instret !== 32'd2) begin
         errors++; $display("FAIL load_retire: got %h/%0d expected %h/2", outs(), bus.instret, v_fetch);
      end
   endtask

   task automatic test_store();
      logic        mr  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [19:0] exp [4];
      exp = '{v_fetch_rdy, v_decode, v_exec_ls,
              ev(1,1,1,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0,0,2'b00)};
      bus.opcode = 5'b01000;
      for (int i = 0; i < 4; i++) begin
         bus.mem_ready = mr[i];
         #1;
         checks++;
         if (outs() !== exp[i]) begin
            errors++; $display("FAIL store cycle %0d: got %h expected %h", i, outs(), exp[i]);
         end
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (outs() !== v_fetch || bus.instret !== 32'd3) begin
         errors++; $display("FAIL store_retire: got %h/%0d expected %h/3", outs(), bus.instret, v_fetch);
      end
   endtask

   task automatic test_branch_jal();
      logic [19:0] exp [7];
      logic        mr  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [4:0]  opc [7] = '{5'b11000, 5'b11000, 5'b11000, 5'b11011, 5'b11011, 5'b11011, 5'b11011};
      exp = '{v_fetch_rdy, v_decode, ev(0,0,0,0,0,1,2'b01,2'b00,3'b001,2'b00,0,0,0,2'b00),
              v_fetch_rdy, v_decode, ev(0,0,0,0,1,0,2'b00,2'b10,3'b000,2'b00,0,0,0,2'b00),
              ev(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b10,1,0,0,2'b00)};
      for (int i = 0; i < 7; i++) begin
         bus.mem_ready = mr[i];
         bus.opcode    = opc[i];
         #1;
         checks++;
         if (outs() !== exp[i]) begin
            errors++; $display("FAIL branch_jal cycle %0d: got %h expected %h", i, outs(), exp[i]);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (bus.instret !== 32'd5) begin
         errors++; $display("FAIL branch_jal_retire: got %0d expected 5", bus.instret);
      end
   endtask

   task automatic test_mid_reset();
      bus.opcode = 5'b01100;
      bus.mem_ready = 1'b1;
      #1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (outs() !== v_exec_r) begin
         errors++; $display("FAIL mid_reset_exec: got %h expected %h", outs(), v_exec_r);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs() !== v_zero || bus.instret !== 32'd0) begin
         errors++; $display("FAIL mid_reset_clear: got %h/%0d expected %h/0", outs(), bus.instret, v_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      logic [19:0] v_halt;
      v_halt = ev(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0,1,2'b10);
      apply_reset();
      for (int i = 0; i < 15; i++) begin
         #1;
         checks++;
         if (outs() !== v_fetch) begin
            errors++; $display("FAIL timeout_fetch cycle %0d: got %h expected %h", i, outs(), v_fetch);
         end
         @(negedge clk);
      end
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (outs() !== v_halt || bus.instret !== 32'd0) begin
            errors++; $display("FAIL timeout_halt cycle %0d: got %h/%0d expected %h/0", i, outs(), bus.instret, v_halt);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_timeout_boundary_system();
      apply_reset();
      bus.opcode = 5'b11100;
      repeat (14) @(negedge clk);
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (outs() !== v_fetch_rdy) begin
         errors++; $display("FAIL boundary_ready: got %h expected %h", outs(), v_fetch_rdy);
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (outs() !== v_decode) begin
         errors++; $display("FAIL boundary_decode: got %h expected %h", outs(), v_decode);
      end
      @(negedge clk);
      #1;
      checks++;
      if (outs() !== ev(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0,1,2'b00)) begin
         errors++; $display("FAIL system_halt: got %h expected halted fault 00", outs());
      end
      @(negedge clk);
   endtask

   task automatic test_illegal();
      apply_reset();
      bus.opcode = 5'b11111;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (outs() !== ev(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0,1,2'b01)) begin
            errors++; $display("FAIL illegal_halt cycle %0d: got %h expected halted fault 01", i, outs());
         end
         @(negedge clk);
      end
   endtask

`ifdef MULTICYCLE_MDU_EN
   task automatic test_mdu();
      logic [19:0] v_mdu_exec;
      v_mdu_exec = ev(0,0,0,0,0,0,2'b01,2'b00,3'b010,2'b00,0,1,0,2'b00);
      apply_reset();
      bus.opcode = 5'b01100;
      bus.funct7_b0 = 1'b1;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (outs() !== v_mdu_exec) begin
         errors++; $display("FAIL mdu_exec: got %h expected %h", outs(), v_mdu_exec);
      end
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         bus.mdu_done = (i == 4);
         #1;
         checks++;
         if (outs() !== v_zero) begin
            errors++; $display("FAIL mdu_wait cycle %0d: got %h expected %h", i, outs(), v_zero);
         end
         @(negedge clk);
      end
      bus.mdu_done = 1'b0;
      #1;
      checks++;
      if (outs() !== ev(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b11,1,0,0,2'b00)) begin
         errors++; $display("FAIL mdu_wb: got %h expected wb_sel 11 with reg_write", outs());
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.instret !== 32'd1) begin
         errors++; $display("FAIL mdu_retire: got %0d expected 1", bus.instret);
      end
   endtask
`else
   task automatic test_mdu();
      apply_reset();
      bus.opcode = 5'b01100;
      bus.funct7_b0 = 1'b1;
      bus.mdu_done = 1'b1;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (outs() !== v_exec_r) begin
         errors++; $display("FAIL nomdu_exec: got %h expected %h", outs(), v_exec_r);
      end
      @(negedge clk);
      #1;
      checks++;
      if (outs() !== v_wb_alu) begin
         errors++; $display("FAIL nomdu_wb: got %h expected %h", outs(), v_wb_alu);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.opcode = 5'b0;
      bus.funct7_b0 = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mdu_done = 1'b0;
      v_zero      = 20'h0;
      v_fetch     = ev(1,0,0,0,0,0,2'b00,2'b01,3'b000,2'b00,0,0,0,2'b00);
      v_fetch_rdy = ev(1,0,0,1,1,0,2'b00,2'b01,3'b000,2'b00,0,0,0,2'b00);
      v_decode    = ev(0,0,0,0,0,0,2'b00,2'b10,3'b000,2'b00,0,0,0,2'b00);
      v_exec_r    = ev(0,0,0,0,0,0,2'b01,2'b00,3'b010,2'b00,0,0,0,2'b00);
      v_exec_ls   = ev(0,0,0,0,0,0,2'b01,2'b10,3'b000,2'b00,0,0,0,2'b00);
      v_wb_alu    = ev(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,1,0,0,2'b00);

      test_reset();
      test_rtype();
      test_load();
      test_store();
      test_branch_jal();
      test_mid_reset();
      test_timeout();
      test_timeout_boundary_system();
      test_illegal();
      test_mdu();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
